// File: rtl/commit_pkg.sv
// Shared state encoding, RISC-V exception cause codes, exception flag bundle
// and the solo-instruction helper used by the commit scheduler.
package commit_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_SB = 2'd1,
        TRAP    = 2'd2,
        FLUSH   = 2'd3
    } commit_state_e;

    // Field order follows cause priority, highest first.
    typedef struct packed {
        logic instr_addrmis;
        logic instr_pageflt;
        logic instr_accflt;
        logic illins;
        logic ebreak;
        logic ecall;
        logic load_addrmis;
        logic store_addrmis;
        logic load_pageflt;
        logic store_pageflt;
        logic load_accflt;
        logic store_accflt;
    } exc_flags_t;

    localparam logic [3:0] CAUSE_INSTR_ADDRMIS = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_ACCFLT  = 4'd1;
    localparam logic [3:0] CAUSE_ILLINS        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT    = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_ADDRMIS  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCFLT   = 4'd5;
    localparam logic [3:0] CAUSE_STORE_ADDRMIS = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCFLT  = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M       = 4'd11;
    localparam logic [3:0] CAUSE_INSTR_PAGEFLT = 4'd12;
    localparam logic [3:0] CAUSE_LOAD_PAGEFLT  = 4'd13;
    localparam logic [3:0] CAUSE_STORE_PAGEFLT = 4'd15;

    // A solo instruction must retire alone: nothing may retire beside it.
    function automatic logic is_solo(
        input exc_flags_t exc,
        input logic       jump,
        input logic       mret,
        input logic       sret,
        input logic       csren,
        input logic       fflagen,
        input logic       irrevo,
        input logic       mmio
    );
        return (|exc) | jump | mret | sret | csren | fflagen | irrevo | mmio;
    endfunction

endpackage

// File: rtl/pip_flush_interface.sv
// Single-bit pipeline flush request.
interface pip_flush_interface;
    logic flush;

    modport master (output flush);
    modport slave  (input  flush);
endinterface

// File: rtl/pip_robread_interface.sv
// Read port of one ROB head entry; the commit side only drives ready.
interface pip_robread_interface;
    logic                  valid;
    logic                  complete;
    logic                  ready;
    logic [63:0]           pc;
    logic [63:0]           branchaddr;
    logic                  jump;
    logic                  mret;
    logic                  sret;
    logic                  csren;
    logic                  fflagen;
    logic                  irrevo;
    logic                  mmio;
    commit_pkg::exc_flags_t exc;

    modport master (
        output valid, complete, pc, branchaddr, jump, mret, sret,
               csren, fflagen, irrevo, mmio, exc,
        input  ready
    );

    modport slave (
        input  valid, complete, pc, branchaddr, jump, mret, sret,
               csren, fflagen, irrevo, mmio, exc,
        output ready
    );
endinterface

// File: rtl/commit_cause_encode.sv
// Priority encoder from the exception flag bundle to a 4-bit RISC-V cause code.
module commit_cause_encode
    import commit_pkg::*;
(
    input  exc_flags_t  exc_i,
    output logic        any_o,
    output logic [3:0]  cause_o
);

    always_comb begin
        any_o   = |exc_i;
        cause_o = 4'd0;
        if (exc_i.instr_addrmis)      cause_o = CAUSE_INSTR_ADDRMIS;
        else if (exc_i.instr_pageflt) cause_o = CAUSE_INSTR_PAGEFLT;
        else if (exc_i.instr_accflt)  cause_o = CAUSE_INSTR_ACCFLT;
        else if (exc_i.illins)        cause_o = CAUSE_ILLINS;
        else if (exc_i.ebreak)        cause_o = CAUSE_BREAKPOINT;
        else if (exc_i.ecall)         cause_o = CAUSE_ECALL_M;
        else if (exc_i.load_addrmis)  cause_o = CAUSE_LOAD_ADDRMIS;
        else if (exc_i.store_addrmis) cause_o = CAUSE_STORE_ADDRMIS;
        else if (exc_i.load_pageflt)  cause_o = CAUSE_LOAD_PAGEFLT;
        else if (exc_i.store_pageflt) cause_o = CAUSE_STORE_PAGEFLT;
        else if (exc_i.load_accflt)   cause_o = CAUSE_LOAD_ACCFLT;
        else if (exc_i.store_accflt)  cause_o = CAUSE_STORE_ACCFLT;
    end

endmodule

// File: rtl/commit_scheduler.sv
// Retires ROB head entries and sequences trap, fetch redirect and flush.
// Dual retire of instr1 is built only when COMMIT_DUAL_EN is defined.
module commit_scheduler
    import commit_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       arst_i,
    pip_robread_interface.slave        instr0,
    pip_robread_interface.slave        instr1,
    pip_flush_interface.master         flush_master,
    input  logic                       sb_empty_i,
    output logic                       trap_valid_o,
    output logic [3:0]                 trap_cause_o,
    output logic [63:0]                trap_pc_o,
    output logic                       redirect_valid_o,
    output logic [63:0]                redirect_pc_o,
    output logic [1:0]                 retire_cnt_o
);

    commit_state_e state_q, state_d;
    logic [3:0]    cause_q, cause_d;
    logic [63:0]   tpc_q, tpc_d;
    logic          redir_q, redir_d;
    logic [63:0]   rpc_q, rpc_d;

    logic          exc0_any;
    logic [3:0]    exc0_cause;
    logic          i0_vc;
    logic          i1_vc;
    logic          i0_ctrl;
    logic          solo0;
    logic          solo1;
    logic          dual_ok;
    logic          ready0;
    logic          ready1;
    logic          ready0_g;
    logic          ready1_g;

    commit_cause_encode u_cause (
        .exc_i   (instr0.exc),
        .any_o   (exc0_any),
        .cause_o (exc0_cause)
    );

    assign i0_vc   = instr0.valid & instr0.complete;
    assign i1_vc   = instr1.valid & instr1.complete;
    assign i0_ctrl = instr0.jump | instr0.mret | instr0.sret;
    assign solo0   = is_solo(instr0.exc, instr0.jump, instr0.mret, instr0.sret,
                             instr0.csren, instr0.fflagen, instr0.irrevo, instr0.mmio);
    assign solo1   = is_solo(instr1.exc, instr1.jump, instr1.mret, instr1.sret,
                             instr1.csren, instr1.fflagen, instr1.irrevo, instr1.mmio);

`ifdef COMMIT_DUAL_EN
    assign dual_ok = i1_vc & ~solo0 & ~solo1;
`else
    logic unused_dual;
    assign dual_ok     = 1'b0;
    assign unused_dual = ^{i1_vc, solo0, solo1};
`endif

    // instr1 never redirects or traps on its own; those only happen once it is instr0.
    logic unused_i1;
    assign unused_i1 = ^{instr1.pc, instr1.branchaddr};

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        tpc_d   = tpc_q;
        redir_d = redir_q;
        rpc_d   = rpc_q;
        ready0  = 1'b0;
        ready1  = 1'b0;

        case (state_q)
            RUN: begin
                if (i0_vc) begin
                    if (exc0_any) begin
                        cause_d = exc0_cause;
                        tpc_d   = instr0.pc;
                        state_d = TRAP;
                    end else if (instr0.irrevo | instr0.mmio) begin
                        state_d = WAIT_SB;
                    end else begin
                        ready0 = 1'b1;
                        ready1 = dual_ok;
                        if (i0_ctrl) begin
                            state_d = FLUSH;
                            redir_d = 1'b1;
                            rpc_d   = instr0.jump ? instr0.branchaddr : 64'd0;
                        end
                    end
                end
            end
            WAIT_SB: begin
                if (sb_empty_i) begin
                    ready0  = 1'b1;
                    state_d = RUN;
                    // An irrevocable control-flow op still owes its redirect.
                    if (i0_ctrl) begin
                        state_d = FLUSH;
                        redir_d = 1'b1;
                        rpc_d   = instr0.jump ? instr0.branchaddr : 64'd0;
                    end
                end
            end
            TRAP: begin
                redir_d = 1'b0;
                state_d = FLUSH;
            end
            FLUSH: begin
                redir_d = 1'b0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= RUN;
            cause_q <= 4'd0;
            tpc_q   <= 64'd0;
            redir_q <= 1'b0;
            rpc_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tpc_q   <= tpc_d;
            redir_q <= redir_d;
            rpc_q   <= rpc_d;
        end
    end

    // Readies are combinational from RUN, so hold them low explicitly during reset.
    assign ready0_g           = ready0 & ~arst_i;
    assign ready1_g           = ready1 & ~arst_i;
    assign instr0.ready       = ready0_g;
    assign instr1.ready       = ready1_g;
    assign retire_cnt_o       = {1'b0, ready0_g} + {1'b0, ready1_g};

    assign trap_valid_o       = (state_q == TRAP);
    assign trap_cause_o       = cause_q;
    assign trap_pc_o          = tpc_q;
    assign flush_master.flush = (state_q == FLUSH);
    assign redirect_valid_o   = (state_q == FLUSH) & redir_q;
    assign redirect_pc_o      = rpc_q;

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: table vectors, directed sequences
// and randomized traffic against an event-queue reference model.
module tb_commit_scheduler;

`ifdef COMMIT_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam logic [11:0] E_IAM = 12'h800, E_IPF = 12'h400, E_IAF = 12'h200,
                            E_ILL = 12'h100, E_BRK = 12'h080, E_ECL = 12'h040,
                            E_LAM = 12'h020, E_SAM = 12'h010, E_LPF = 12'h008,
                            E_SPF = 12'h004, E_LAF = 12'h002, E_SAF = 12'h001;

    logic        clk;
    logic        arst;
    logic        sb_empty;
    logic        trap_valid;
    logic [3:0]  trap_cause;
    logic [63:0] trap_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [1:0]  retire_cnt;

    pip_robread_interface i0_if ();
    pip_robread_interface i1_if ();
    pip_flush_interface   fl_if ();

    commit_scheduler dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .instr0           (i0_if),
        .instr1           (i1_if),
        .flush_master     (fl_if),
        .sb_empty_i       (sb_empty),
        .trap_valid_o     (trap_valid),
        .trap_cause_o     (trap_cause),
        .trap_pc_o        (trap_pc),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .retire_cnt_o     (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic valid, complete, jump, mret, sret, csren, fflagen, irrevo, mmio;
        logic [11:0] exc;
        logic [63:0] pc, baddr;
    } ins_t;

    typedef struct { logic trap, flush, redir; logic [63:0] rpc; } ev_t;

    typedef struct { ins_t a; ins_t b; logic r0; logic r1d; } vec_t;
    typedef struct { logic [11:0] e; logic [3:0] c; } cvec_t;

    // ---------------- reference model ----------------
    ev_t         evq[$];
    bit          m_wait;
    logic [3:0]  m_cause;
    logic [63:0] m_tpc;
    logic        e_r0, e_r1, e_trap, e_flush, e_redir;
    logic [63:0] e_rpc;

    function automatic logic [3:0] cause_of(input logic [11:0] e);
        if ((e & E_IAM) != 0) return 4'd0;
        if ((e & E_IPF) != 0) return 4'd12;
        if ((e & E_IAF) != 0) return 4'd1;
        if ((e & E_ILL) != 0) return 4'd2;
        if ((e & E_BRK) != 0) return 4'd3;
        if ((e & E_ECL) != 0) return 4'd11;
        if ((e & E_LAM) != 0) return 4'd4;
        if ((e & E_SAM) != 0) return 4'd6;
        if ((e & E_LPF) != 0) return 4'd13;
        if ((e & E_SPF) != 0) return 4'd15;
        if ((e & E_LAF) != 0) return 4'd5;
        return 4'd7;
    endfunction

    function automatic bit vc(input ins_t x);
        return x.valid && x.complete;
    endfunction

    function automatic bit ctrl(input ins_t x);
        return x.jump || x.mret || x.sret;
    endfunction

    function automatic bit solo(input ins_t x);
        return (x.exc != 0) || ctrl(x) || x.csren || x.fflagen || x.irrevo || x.mmio;
    endfunction

    function automatic ev_t redir_ev(input ins_t x);
        ev_t r;
        r.trap = 0; r.flush = 1; r.redir = 1;
        r.rpc = x.jump ? x.baddr : 64'd0;
        return r;
    endfunction

    task automatic model_reset();
        evq.delete();
        m_wait  = 0;
        m_cause = 4'd0;
        m_tpc   = 64'd0;
    endtask

    task automatic model_step(input ins_t a, input ins_t b, input logic sb);
        ev_t ev;
        ev_t t;
        ev.trap = 0; ev.flush = 0; ev.redir = 0; ev.rpc = 64'd0;
        e_r0 = 0;
        e_r1 = 0;
        if (evq.size() > 0) begin
            ev = evq.pop_front();
        end else if (m_wait) begin
            if (sb) begin
                e_r0   = 1;
                m_wait = 0;
                if (ctrl(a)) evq.push_back(redir_ev(a));
            end
        end else if (vc(a)) begin
            if (a.exc != 0) begin
                t.trap = 1; t.flush = 0; t.redir = 0; t.rpc = 64'd0;
                evq.push_back(t);
                t.trap = 0; t.flush = 1;
                evq.push_back(t);
                m_cause = cause_of(a.exc);
                m_tpc   = a.pc;
            end else if (a.irrevo || a.mmio) begin
                m_wait = 1;
            end else begin
                e_r0 = 1;
                e_r1 = DUAL && vc(b) && !solo(a) && !solo(b);
                if (ctrl(a)) evq.push_back(redir_ev(a));
            end
        end
        e_trap  = ev.trap;
        e_flush = ev.flush;
        e_redir = ev.redir;
        e_rpc   = ev.rpc;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic ins_t idle_ins();
        ins_t r;
        r.valid = 0; r.complete = 0; r.jump = 0; r.mret = 0; r.sret = 0;
        r.csren = 0; r.fflagen = 0; r.irrevo = 0; r.mmio = 0;
        r.exc = 12'd0; r.pc = 64'd0; r.baddr = 64'd0;
        return r;
    endfunction

    function automatic ins_t alu(input logic [63:0] pc);
        ins_t r = idle_ins();
        r.valid = 1; r.complete = 1; r.pc = pc;
        return r;
    endfunction

    function automatic logic pct(input int p);
        return ($urandom_range(0, 99) < p);
    endfunction

    function automatic ins_t rnd_ins();
        ins_t r = idle_ins();
        r.valid    = pct(85);
        r.complete = pct(85);
        if (pct(8)) r.exc = 12'($urandom_range(1, 4095));
        r.jump    = pct(8);
        r.mret    = pct(3);
        r.sret    = pct(3);
        r.csren   = pct(5);
        r.fflagen = pct(5);
        r.irrevo  = pct(4);
        r.mmio    = pct(4);
        r.pc      = {$urandom, $urandom};
        r.baddr   = {$urandom, $urandom};
        return r;
    endfunction

    task automatic apply(input ins_t a, input ins_t b, input logic sb);
        i0_if.valid = a.valid;     i0_if.complete = a.complete;
        i0_if.jump = a.jump;       i0_if.mret = a.mret;     i0_if.sret = a.sret;
        i0_if.csren = a.csren;     i0_if.fflagen = a.fflagen;
        i0_if.irrevo = a.irrevo;   i0_if.mmio = a.mmio;     i0_if.exc = a.exc;
        i0_if.pc = a.pc;           i0_if.branchaddr = a.baddr;
        i1_if.valid = b.valid;     i1_if.complete = b.complete;
        i1_if.jump = b.jump;       i1_if.mret = b.mret;     i1_if.sret = b.sret;
        i1_if.csren = b.csren;     i1_if.fflagen = b.fflagen;
        i1_if.irrevo = b.irrevo;   i1_if.mmio = b.mmio;     i1_if.exc = b.exc;
        i1_if.pc = b.pc;           i1_if.branchaddr = b.baddr;
        sb_empty = sb;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input string tag);
        chk({tag, ".ready0"}, 64'(i0_if.ready), 64'(e_r0));
        chk({tag, ".ready1"}, 64'(i1_if.ready), 64'(e_r1));
        chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(e_r0) + 64'(e_r1));
        chk({tag, ".trap_valid"}, 64'(trap_valid), 64'(e_trap));
        chk({tag, ".flush"}, 64'(fl_if.flush), 64'(e_flush));
        chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(e_redir));
        if (e_trap) begin
            chk({tag, ".trap_cause"}, 64'(trap_cause), 64'(m_cause));
            chk({tag, ".trap_pc"}, trap_pc, m_tpc);
        end
        if (e_redir) chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    endtask

    // Entered at posedge+1; checks at posedge+4, returns before the next edge.
    task automatic drive_and_check(input ins_t a, input ins_t b, input logic sb, input string tag);
        apply(a, b, sb);
        model_step(a, b, sb);
        #3;
        check_cycle(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input ins_t a, input ins_t b, input logic sb, input string tag);
        drive_and_check(a, b, sb, tag);
        tick();
    endtask

    task automatic mid_reset(input string tag);
        arst = 1'b1;
        #2;
        chk({tag, ".rst_trap_valid"}, 64'(trap_valid), 64'd0);
        chk({tag, ".rst_flush"}, 64'(fl_if.flush), 64'd0);
        chk({tag, ".rst_redirect"}, 64'(redirect_valid), 64'd0);
        chk({tag, ".rst_ready0"}, 64'(i0_if.ready), 64'd0);
        chk({tag, ".rst_ready1"}, 64'(i1_if.ready), 64'd0);
        chk({tag, ".rst_cause"}, 64'(trap_cause), 64'd0);
        chk({tag, ".rst_tpc"}, trap_pc, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        vec_t  vt[$];
        cvec_t ct[$];
        vec_t  v;
        ins_t  a;
        ins_t  b;
        ins_t  idl;

        idl = idle_ins();

        // reset: readies held low even with retirable entries presented
        arst = 1'b1;
        apply(alu(64'h100), alu(64'h104), 1'b1);
        #3;
        chk("reset.ready0", 64'(i0_if.ready), 64'd0);
        chk("reset.ready1", 64'(i1_if.ready), 64'd0);
        chk("reset.retire_cnt", 64'(retire_cnt), 64'd0);
        chk("reset.trap_valid", 64'(trap_valid), 64'd0);
        chk("reset.flush", 64'(fl_if.flush), 64'd0);
        chk("reset.redirect", 64'(redirect_valid), 64'd0);
        chk("reset.cause", 64'(trap_cause), 64'd0);
        chk("reset.tpc", trap_pc, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst = 1'b0;
        model_reset();

        // table: single-cycle retire decisions from RUN
        v.a = alu(64'h200); v.b = alu(64'h204); v.r0 = 1; v.r1d = 1; vt.push_back(v);
        v.a = alu(64'h210); v.b = idl;           v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h220); v.b = alu(64'h224); v.b.complete = 0; v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = idl;          v.b = alu(64'h234); v.r0 = 0; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h240); v.a.complete = 0; v.b = alu(64'h244); v.r0 = 0; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h250); v.a.csren = 1;   v.b = alu(64'h254); v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h260); v.b = alu(64'h264); v.b.csren = 1;   v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h270); v.a.fflagen = 1; v.b = alu(64'h274); v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h280); v.b = alu(64'h284); v.b.exc = E_ECL; v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h290); v.b = alu(64'h294); v.b.jump = 1;    v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h2a0); v.b = alu(64'h2a4); v.b.mmio = 1;    v.r0 = 1; v.r1d = 0; vt.push_back(v);
        v.a = alu(64'h2b0); v.b = alu(64'h2b4); v.b.irrevo = 1;  v.r0 = 1; v.r1d = 0; vt.push_back(v);

        foreach (vt[i]) begin
            drive_and_check(vt[i].a, vt[i].b, 1'b1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_ready0", i), 64'(i0_if.ready), 64'(vt[i].r0));
            chk($sformatf("tbl%0d.exp_ready1", i), 64'(i1_if.ready), 64'(DUAL & vt[i].r1d));
            chk($sformatf("tbl%0d.exp_cnt", i), 64'(retire_cnt),
                64'(vt[i].r0) + 64'(DUAL & vt[i].r1d));
            tick();
        end

        // table: exception cause priority through the full trap sequence
        ct.push_back('{E_IAM, 4'd0});  ct.push_back('{E_IPF, 4'd12}); ct.push_back('{E_IAF, 4'd1});
        ct.push_back('{E_ILL, 4'd2});  ct.push_back('{E_BRK, 4'd3});  ct.push_back('{E_ECL, 4'd11});
        ct.push_back('{E_LAM, 4'd4});  ct.push_back('{E_SAM, 4'd6});  ct.push_back('{E_LPF, 4'd13});
        ct.push_back('{E_SPF, 4'd15}); ct.push_back('{E_LAF, 4'd5});  ct.push_back('{E_SAF, 4'd7});
        ct.push_back('{E_IAM | E_ECL, 4'd0});  ct.push_back('{E_IPF | E_ILL, 4'd12});
        ct.push_back('{E_BRK | E_ECL, 4'd3});  ct.push_back('{E_LAF | E_SPF, 4'd15});
        ct.push_back('{E_ILL | E_LAM, 4'd2});  ct.push_back('{E_IAF | E_ILL, 4'd1});
        foreach (ct[i]) begin
            a = alu(64'h8000_0000 + 64'(i * 16));
            a.exc = ct[i].e;
            drive_and_check(a, alu(64'h4), 1'b1, $sformatf("cause%0d.detect", i));
            tick();
            drive_and_check(idl, idl, 1'b1, $sformatf("cause%0d.trap", i));
            chk($sformatf("cause%0d.code", i), 64'(trap_cause), 64'(ct[i].c));
            tick();
            cycle(idl, idl, 1'b1, $sformatf("cause%0d.flush", i));
        end

        // load page fault: trap one cycle later, flush the cycle after
        a = alu(64'h8000_1000); a.exc = E_LPF;
        drive_and_check(a, alu(64'h8000_1004), 1'b0, "lpf.detect");
        chk("lpf.no_ready", 64'(i0_if.ready), 64'd0);
        tick();
        drive_and_check(a, alu(64'h8000_1004), 1'b0, "lpf.trap");
        chk("lpf.trap_valid", 64'(trap_valid), 64'd1);
        chk("lpf.trap_cause", 64'(trap_cause), 64'd13);
        chk("lpf.trap_pc", trap_pc, 64'h8000_1000);
        tick();
        drive_and_check(idl, idl, 1'b0, "lpf.flush");
        chk("lpf.flush", 64'(fl_if.flush), 64'd1);
        chk("lpf.flush_no_trap", 64'(trap_valid), 64'd0);
        tick();

        // mmio store waits for the store buffer to drain
        a = alu(64'h8000_3000); a.mmio = 1;
        for (int c = 1; c <= 6; c++) begin
            drive_and_check(a, alu(64'h8000_3004), (c == 6), $sformatf("mmio.c%0d", c));
            chk($sformatf("mmio.c%0d.ready0", c), 64'(i0_if.ready), 64'(c == 6));
            chk($sformatf("mmio.c%0d.ready1", c), 64'(i1_if.ready), 64'd0);
            tick();
        end
        cycle(idl, idl, 1'b0, "mmio.after");

        // jump retires alone, then redirect + flush
        a = alu(64'h8000_0ff0); a.jump = 1; a.baddr = 64'h8000_2000;
        drive_and_check(a, alu(64'h8000_0ff4), 1'b1, "jump.retire");
        chk("jump.cnt", 64'(retire_cnt), 64'd1);
        tick();
        drive_and_check(alu(64'h8000_2000), alu(64'h8000_2004), 1'b1, "jump.redirect");
        chk("jump.redirect_valid", 64'(redirect_valid), 64'd1);
        chk("jump.redirect_pc", redirect_pc, 64'h8000_2000);
        chk("jump.flush", 64'(fl_if.flush), 64'd1);
        chk("jump.flush_ready0", 64'(i0_if.ready), 64'd0);
        tick();

        // mret: redirect with pc 0 and no trap
        a = alu(64'h8000_4000); a.mret = 1; a.baddr = 64'h1234_5678;
        cycle(a, alu(64'h8000_4004), 1'b1, "mret.retire");
        drive_and_check(idl, idl, 1'b1, "mret.redirect");
        chk("mret.redirect_pc", redirect_pc, 64'd0);
        chk("mret.no_trap", 64'(trap_valid), 64'd0);
        tick();

        // reset in TRAP aborts the trap and flush
        a = alu(64'h8000_5000); a.exc = E_ILL;
        cycle(a, idl, 1'b1, "rsttrap.detect");
        mid_reset("rsttrap");
        cycle(idl, idl, 1'b1, "rsttrap.after");
        drive_and_check(alu(64'h10), alu(64'h14), 1'b1, "rsttrap.run");
        chk("rsttrap.run_ready0", 64'(i0_if.ready), 64'd1);
        tick();

        // reset in WAIT_SB
        a = alu(64'h8000_6000); a.irrevo = 1;
        cycle(a, idl, 1'b0, "rstwait.detect");
        cycle(a, idl, 1'b0, "rstwait.wait");
        mid_reset("rstwait");
        cycle(idl, idl, 1'b1, "rstwait.after");

        // reset in FLUSH cancels the redirect
        a = alu(64'h8000_7000); a.jump = 1; a.baddr = 64'h8000_7100;
        cycle(a, idl, 1'b1, "rstflush.retire");
        mid_reset("rstflush");
        cycle(idl, idl, 1'b1, "rstflush.after");

        // two ALU ops: both in one cycle with dual retire, one per cycle without
        drive_and_check(alu(64'h9000), alu(64'h9004), 1'b1, "pair.c1");
        chk("pair.c1_cnt", 64'(retire_cnt), DUAL ? 64'd2 : 64'd1);
        tick();
        drive_and_check(alu(64'h9004), idl, 1'b1, "pair.c2");
        chk("pair.c2_cnt", 64'(retire_cnt), 64'd1);
        tick();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            a = rnd_ins();
            b = rnd_ins();
            cycle(a, b, pct(40), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_scheduler.md
COMMIT_SCHEDULER -- requirements
Module: commit_scheduler

Interface
REQ-001 SHALL have clk_i, input, 1: single clock; all state on posedge.
REQ-002 SHALL have arst_i, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have instr0, pip_robread_interface.slave, bundle: oldest ROB head entry; block drives ready only.
REQ-004 SHALL have instr1, pip_robread_interface.slave, bundle: second-oldest entry; block drives ready only.
REQ-005 SHALL have flush_master, pip_flush_interface.master, bundle: drives flush.
REQ-006 SHALL have sb_empty_i, input, 1: store buffer drained.
REQ-007 SHALL have trap_valid_o, output, 1: one-cycle trap request to CSR unit.
REQ-008 SHALL have trap_cause_o, output, 4: RISC-V exception code.
REQ-009 SHALL have trap_pc_o, output, 64: pc of the faulting instruction.
REQ-010 SHALL have redirect_valid_o, output, 1, and redirect_pc_o, output, 64: fetch redirect.
REQ-011 SHALL have retire_cnt_o, output, 2: instructions retired this cycle (0..2).

Function
REQ-012 SHALL implement states RUN, WAIT_SB, TRAP, FLUSH.
REQ-013 Retire rule: instr0.ready=1 only in RUN with instr0.valid&complete, no exception, not irrevo/mmio; or in WAIT_SB when sb_empty_i=1.
REQ-014 "Solo" instruction: any exception, jump, mret, sret, csren, fflagen, irrevo or mmio.
REQ-015 instr1.ready=1 only when instr0.ready=1 in RUN, instr1.valid&complete, and neither instr0 nor instr1 is solo.
REQ-016 retire_cnt_o SHALL equal instr0.ready+instr1.ready combinationally.
REQ-017 Exception on instr0 (any fault, illins, ecall, ebreak), valid&complete, in RUN: no ready; cause/pc registered; next state TRAP.
REQ-018 TRAP: trap_valid_o=1 for exactly one cycle; then FLUSH.
REQ-019 FLUSH: flush_master.flush=1 for exactly one cycle; all readies 0; then RUN.
REQ-020 Exception cause priority: instr_addrmis > instr_pageflt > instr_accflt > illins > ebreak > ecall > load/store addr_mis > load/store page_flt > load/store acc_flt.
REQ-021 instr0 irrevo or mmio, valid&complete, no exception, in RUN: next state WAIT_SB; in WAIT_SB retire instr0 alone the first cycle sb_empty_i=1, then RUN.
REQ-022 Retired instr0 with jump, mret or sret: redirect_valid_o=1 and flush=1 in the following cycle via FLUSH; redirect_pc_o=registered branchaddr (jump) or 0 and trap_valid_o=0 for mret/sret (CSR unit supplies target).
REQ-023 instr1 SHALL never be retired in the same cycle a flush, trap or redirect is issued.
REQ-024 Latency: ready combinational from inputs in RUN; trap_valid_o 1 cycle after detection; flush 2 cycles after detection.

Reset
REQ-025 On arst_i: state=RUN, trap_valid_o=0, redirect_valid_o=0, flush=0, captured cause/pc=0, both readies 0 while arst_i high.
REQ-026 Reset mid-TRAP/WAIT_SB/FLUSH SHALL abort the sequence without emitting pending trap, redirect or flush.

Configuration
REQ-027 Macro COMMIT_DUAL_EN defined: dual retire per REQ-015.
REQ-028 Macro COMMIT_DUAL_EN undefined: instr1.ready tied 0; retire_cnt_o max 1; all else unchanged.

Structure
REQ-029 Package commit_pkg SHALL hold state enum, 4-bit cause constants, and the solo-condition helper function.
REQ-030 Sub-module commit_cause_encode SHALL implement the REQ-020 priority encoder (combinational).

Verification
REQ-031 Two completed ALU ops, valid&complete both -> both readies 1, retire_cnt_o=2 same cycle.
REQ-032 instr0 load_page_flt pc=0x8000_1000 -> no ready; next cycle trap_valid_o=1, trap_cause_o=13, trap_pc_o=0x8000_1000; next cycle flush=1.
REQ-033 instr0 mmio store, sb_empty_i=0 for 5 cycles then 1 -> readies 0 for 5 cycles, instr0.ready=1 on cycle 6, retire_cnt_o=1.
REQ-034 instr0 jump, branchaddr=0x8000_2000, instr1 valid -> retire_cnt_o=1; next cycle redirect_valid_o=1, redirect_pc_o=0x8000_2000, flush=1.
REQ-035 arst_i asserted in TRAP -> trap_valid_o stays 0, state RUN after release.
REQ-036 Build without COMMIT_DUAL_EN, two ready ALU ops -> retire one per cycle over two cycles.
